// File: rtl/rom_burst_arbiter.sv
// Round-robin burst arbiter sharing one registered-read ROM between NUM_REQ requesters.
// Beats return through a 2-entry response FIFO tagged with requester id and last flag.
module rom_burst_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 29,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*8-1:0]          req_len,
  output logic                          rom_en,
  output logic [ADDR_WIDTH-1:0]         rom_addr,
  input  logic [DATA_WIDTH-1:0]         rom_data,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic [ID_WIDTH-1:0]           rsp_id,
  output logic                          rsp_last,
  output logic                          busy
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                state, state_nxt;
  logic [ID_WIDTH-1:0]   last_grant;
  logic                  win_found;
  logic [ID_WIDTH-1:0]   win_id;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [7:0]            win_len;
  logic                  handshake;

  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [7:0]            beats_left;
  logic [ID_WIDTH-1:0]   cur_id;

  logic                  issue;
  logic                  pop;
  logic                  push;
  logic [1:0]            count;

  logic                  vld_p0;
  logic [ID_WIDTH-1:0]   id_p0;
  logic                  last_p0;
  logic [ADDR_WIDTH-1:0] rom_addr_p0;

  logic [DATA_WIDTH-1:0] fifo_data [2];
  logic [ID_WIDTH-1:0]   fifo_id   [2];
  logic                  fifo_last [2];
  logic                  wr_ptr;
  logic                  rd_ptr;

  // Distance of requester k from the slot just after the previous winner.
  function automatic int rr_dist(input int k, input int lg);
    return (k + NUM_REQ - 1 - lg) % NUM_REQ;
  endfunction

  always_comb begin : arbitrate
    int best;
    best      = NUM_REQ;
    win_found = 1'b0;
    win_id    = '0;
    win_addr  = '0;
    win_len   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (req_valid[k] && (rr_dist(k, int'(last_grant)) < best)) begin
        best      = rr_dist(k, int'(last_grant));
        win_found = 1'b1;
        win_id    = ID_WIDTH'(k);
        win_addr  = req_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
        win_len   = req_len[k*8 +: 8];
      end
    end
  end

  assign pop = rsp_valid & rsp_ready;
  // A beat may only issue if the FIFO can absorb it once it returns, counting this cycle's pop.
  assign issue = (state == BURST) && !rst &&
                 (({1'b0, count} + {2'b00, vld_p0}) < (3'd2 + {2'b00, pop}));
  assign handshake = (state == IDLE) && win_found && !rst;

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    case (state)
      IDLE: begin
        if (handshake) begin
          req_ready = NUM_REQ'(1) << win_id;
          state_nxt = BURST;
        end
      end
      BURST: begin
        if (issue && (beats_left == 8'd0)) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= ID_WIDTH'(NUM_REQ - 1);
    end else begin
      state <= state_nxt;
      if (handshake) begin
        last_grant <= win_id;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (handshake) begin
      cur_addr   <= win_addr;
      beats_left <= win_len;
      cur_id     <= win_id;
    end else if (issue) begin
      cur_addr   <= cur_addr + 1'b1;
      beats_left <= beats_left - 8'd1;
    end
  end

  assign rom_en   = issue;
  assign rom_addr = issue ? cur_addr : rom_addr_p0;

  // Stage p0: beat issued to the ROM, data arrives on rom_data next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0      <= 1'b0;
      rom_addr_p0 <= '0;
    end else begin
      vld_p0 <= issue;
      if (issue) begin
        rom_addr_p0 <= cur_addr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (issue) begin
      id_p0   <= cur_id;
      last_p0 <= (beats_left == 8'd0);
    end
  end

  // Stage p1: ROM word captured into the response FIFO.
  assign push = vld_p0;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= rom_data;
      fifo_id[wr_ptr]   <= id_p0;
      fifo_last[wr_ptr] <= last_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Outputs read as zero while the FIFO is empty.
  assign rsp_valid = (count != 2'd0);
  assign rsp_data  = rsp_valid ? fifo_data[rd_ptr] : '0;
  assign rsp_id    = rsp_valid ? fifo_id[rd_ptr]   : '0;
  assign rsp_last  = rsp_valid ? fifo_last[rd_ptr] : 1'b0;

  assign busy = (state == BURST) | vld_p0 | (count != 2'd0);

endmodule

// File: tb/tb_rom_burst_arbiter.sv
// Scoreboard bench for rom_burst_arbiter: stimulus queues expected beats and ROM addresses,
// a negedge monitor pops and compares whenever the DUT issues or presents a response.
module tb_rom_burst_arbiter;

  localparam int AW = 29;
  localparam int DW = 64;

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  id;
    logic        last;
  } beat_t;

  logic           clk = 1'b0;
  logic           rst;
  logic [3:0]     req_valid;
  logic [3:0]     req_ready;
  logic [4*AW-1:0] req_addr;
  logic [31:0]    req_len;
  logic           rom_en;
  logic [AW-1:0]  rom_addr;
  logic [DW-1:0]  rom_data = '0;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [DW-1:0]  rsp_data;
  logic [1:0]     rsp_id;
  logic           rsp_last;
  logic           busy;

  logic [1:0]     w_req_valid;
  logic [1:0]     w_req_ready;
  logic [7:0]     w_req_addr;
  logic [15:0]    w_req_len;
  logic           w_rom_en;
  logic [3:0]     w_rom_addr;
  logic [7:0]     w_rom_data = '0;
  logic           w_rsp_valid;
  logic           w_rsp_ready;
  logic [7:0]     w_rsp_data;
  logic           w_rsp_id;
  logic           w_rsp_last;
  logic           w_busy;

  int checks = 0;
  int fails = 0;
  int cyc = 0;
  int occ = 0;
  int npop = 0;
  int last_pop_cyc = 0;
  beat_t exp_q[$];
  logic [AW-1:0] addr_q[$];

  rom_burst_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_len(req_len), .rom_en(rom_en), .rom_addr(rom_addr),
    .rom_data(rom_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_last(rsp_last), .busy(busy)
  );

  rom_burst_arbiter #(.NUM_REQ(2), .ADDR_WIDTH(4), .DATA_WIDTH(8)) dut_w (
    .clk(clk), .rst(rst), .req_valid(w_req_valid), .req_ready(w_req_ready),
    .req_addr(w_req_addr), .req_len(w_req_len), .rom_en(w_rom_en), .rom_addr(w_rom_addr),
    .rom_data(w_rom_data), .rsp_valid(w_rsp_valid), .rsp_ready(w_rsp_ready),
    .rsp_data(w_rsp_data), .rsp_id(w_rsp_id), .rsp_last(w_rsp_last), .busy(w_busy)
  );

  function automatic logic [63:0] rom_word(input logic [AW-1:0] a);
    return {3'b000, a, 16'hC0DE, a[15:0]};
  endfunction

  // ROM models with one cycle registered read.
  always @(posedge clk) begin
    if (rom_en) rom_data <= rom_word(rom_addr);
    if (w_rom_en) w_rom_data <= {4'h5, w_rom_addr};
  end

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    fails++;
    $display("FAIL %s: event missing or unexpected (cycle %0d)", name, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_burst(input int id, input logic [AW-1:0] addr, input int len);
    beat_t b;
    logic [AW-1:0] a;
    for (int k = 0; k <= len; k++) begin
      a = addr + AW'(k);
      b.data = rom_word(a);
      b.id = 2'(id);
      b.last = (k == len);
      exp_q.push_back(b);
      addr_q.push_back(a);
    end
  endtask

  task automatic set_req(input int id, input logic [AW-1:0] addr, input logic [7:0] len);
    req_addr[id*AW +: AW] = addr;
    req_len[id*8 +: 8] = len;
  endtask

  task automatic wait_grant(input int id, output int t);
    int got;
    got = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (req_ready[id]) begin
        got = 1;
        break;
      end
    end
    t = cyc;
    check("grant_seen", 64'(got), 64'd1);
    @(posedge clk);
    #1;
    req_valid[id] = 1'b0;
  endtask

  task automatic wait_drain(input int maxc, input bit toggle);
    int done;
    done = 0;
    for (int c = 0; c < maxc; c++) begin
      if (exp_q.size() == 0 && addr_q.size() == 0 && !busy) begin
        done = 1;
        break;
      end
      tick();
      if (toggle) rsp_ready = ~rsp_ready;
    end
    rsp_ready = 1'b1;
    if (!done) fail_now("drain_timeout");
  endtask

  // Monitor: responses, ROM issues and the FIFO occupancy bound.
  initial forever begin
    beat_t e;
    logic p;
    @(negedge clk);
    if (rst) begin
      occ = 0;
    end else begin
      p = rsp_valid && rsp_ready;
      if (p) begin
        if (exp_q.size() == 0) begin
          fail_now("rsp_unexpected");
        end else begin
          e = exp_q.pop_front();
          check("rsp_data", rsp_data, e.data);
          check("rsp_id", 64'(rsp_id), 64'(e.id));
          check("rsp_last", 64'(rsp_last), 64'(e.last));
          last_pop_cyc = cyc;
          npop++;
        end
      end
      if (rom_en) begin
        check("issue_gate", 64'((occ - int'(p)) < 2), 64'd1);
        if (addr_q.size() == 0) fail_now("rom_en_unexpected");
        else check("rom_addr", 64'(rom_addr), 64'(addr_q.pop_front()));
      end
      if (req_ready != 4'b0000) check("req_ready_onehot", 64'($onehot(req_ready)), 64'd1);
      occ = occ + int'(rom_en) - int'(p);
    end
  end

  initial begin
    int t, idx, ng, g0, hs2, nen, np0, got;
    logic en17;
    logic [3:0] drop;
    int gl[5];
    int rr_exp[5];
    logic [7:1] en_exp, vld_exp;
    logic [3:0] wexp[4];

    rr_exp = '{0, 1, 2, 3, 0};
    wexp = '{4'hE, 4'hF, 4'h0, 4'h1};
    rst = 1'b1;
    req_valid = '0;
    req_addr = '0;
    req_len = '0;
    rsp_ready = 1'b1;
    w_req_valid = '0;
    w_req_addr = '0;
    w_req_len = '0;
    w_rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_rom_en", 64'(rom_en), 64'd0);
    check("rst_rom_addr", 64'(rom_addr), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_data", rsp_data, 64'd0);
    check("rst_rsp_id", 64'(rsp_id), 64'd0);
    check("rst_rsp_last", 64'(rsp_last), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    tick();

    // Round-robin: all four request single-beat bursts.
    for (int i = 0; i < 4; i++) set_req(i, AW'(29'h300 + i * 16), 8'd0);
    for (int k = 0; k < 5; k++) push_burst(rr_exp[k], AW'(29'h300 + rr_exp[k] * 16), 0);
    for (int k = 0; k < 5; k++) gl[k] = -1;
    req_valid = 4'hF;
    ng = 0;
    g0 = 0;
    drop = '0;
    for (int c = 0; c < 80 && ng < 5; c++) begin
      @(negedge clk);
      if (req_ready != 4'b0000) begin
        idx = 0;
        for (int i = 0; i < 4; i++) if (req_ready[i]) idx = i;
        gl[ng] = idx;
        ng++;
        if (idx == 0) begin
          g0++;
          if (g0 == 2) drop[0] = 1'b1;
        end else begin
          drop[idx] = 1'b1;
        end
      end
      @(posedge clk);
      #1;
      req_valid = req_valid & ~drop;
      drop = '0;
    end
    req_valid = '0;
    check("rr_grant_count", 64'(ng), 64'd5);
    for (int k = 0; k < 5; k++) check("rr_grant_order", 64'(gl[k]), 64'(rr_exp[k]));
    wait_drain(50, 1'b0);

    // Single 4-beat burst from requester 2 with latency checks.
    en_exp = 7'b0001111;
    vld_exp = 7'b0111100;
    set_req(2, 29'h10, 8'd3);
    push_burst(2, 29'h10, 3);
    req_valid[2] = 1'b1;
    @(negedge clk);
    check("single_grant", 64'(req_ready), 64'h4);
    @(posedge clk);
    #1;
    req_valid[2] = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      check("single_rom_en_timing", 64'(rom_en), 64'(en_exp[k]));
      check("single_rsp_valid_timing", 64'(rsp_valid), 64'(vld_exp[k]));
      if (k == 1) check("single_busy", 64'(busy), 64'd1);
    end
    tick();
    wait_drain(50, 1'b0);

    // Backpressure: 8-beat burst with rsp_ready toggling every cycle.
    np0 = npop;
    set_req(3, 29'h40, 8'd7);
    push_burst(3, 29'h40, 7);
    req_valid[3] = 1'b1;
    wait_grant(3, t);
    wait_drain(100, 1'b1);
    check("bp_beat_count", 64'(npop - np0), 64'd8);

    // Reset during beat 3 of an 8-beat burst.
    set_req(1, 29'h80, 8'd7);
    push_burst(1, 29'h80, 7);
    req_valid[1] = 1'b1;
    wait_grant(1, t);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    addr_q.delete();
    set_req(0, 29'h500, 8'd0);
    set_req(2, 29'h600, 8'd0);
    set_req(3, 29'h700, 8'd0);
    push_burst(0, 29'h500, 0);
    req_valid = 4'b1101;
    @(negedge clk);
    check("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_rom_en", 64'(rom_en), 64'd0);
    check("mid_rst_grant", 64'(req_ready), 64'h1);
    @(posedge clk);
    #1;
    req_valid = '0;
    wait_drain(50, 1'b0);

    // Full throughput: two back-to-back 16-beat bursts.
    set_req(1, 29'h1000, 8'd15);
    set_req(2, 29'h2000, 8'd15);
    push_burst(1, 29'h1000, 15);
    push_burst(2, 29'h2000, 15);
    req_valid[1] = 1'b1;
    req_valid[2] = 1'b1;
    got = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (req_ready[1]) begin
        got = 1;
        break;
      end
    end
    check("tp_grant1", 64'(got), 64'd1);
    t = cyc;
    hs2 = 0;
    nen = 0;
    en17 = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) req_valid[1] = 1'b0;
      if (hs2 != 0 && k == hs2 + 1) req_valid[2] = 1'b0;
      @(negedge clk);
      if (k <= 33) nen += int'(rom_en);
      if (k == 17) en17 = rom_en;
      if (req_ready[2] && hs2 == 0) hs2 = k;
    end
    req_valid = '0;
    check("tp_second_grant", 64'(hs2), 64'd17);
    check("tp_issue_count", 64'(nen), 64'd32);
    check("tp_bubble", 64'(en17), 64'd0);
    check("tp_last_rsp_cycle", 64'(last_pop_cyc - t), 64'd35);
    check("tp_sb_empty", 64'(exp_q.size()), 64'd0);
    tick();
    wait_drain(50, 1'b0);

    // Address wrap on a 4-bit ROM.
    w_req_addr[3:0] = 4'hE;
    w_req_len[7:0] = 8'd3;
    w_req_valid[0] = 1'b1;
    @(negedge clk);
    check("wrap_grant", 64'(w_req_ready), 64'h1);
    @(posedge clk);
    #1;
    w_req_valid = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("wrap_rom_en", 64'(w_rom_en), 64'd1);
      check("wrap_rom_addr", 64'(w_rom_addr), 64'(wexp[k]));
    end
    got = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (w_rsp_valid && w_rsp_last) begin
        got = 1;
        check("wrap_last_data", 64'(w_rsp_data), 64'h51);
        break;
      end
    end
    check("wrap_last_seen", 64'(got), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
